// File: rtl/seven_segment_pkg.sv
// seven_segment_pkg
//   Shared definitions for the seven-segment scanner slice:
//   - scan_state_t : scanner FSM states (BLANK gap between digits, DRIVE a digit)
//   - DEFAULT_*    : default parameter values used by seven_segment_scanner
package seven_segment_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_t;

  localparam int DEFAULT_NUM_DIGITS   = 4;
  localparam int DEFAULT_REFRESH_DIV  = 100000;
  localparam int DEFAULT_BLANK_CYCLES = 16;

endpackage

// File: rtl/seven_segment_prescaler.sv
// seven_segment_prescaler
//   Cycle counter with terminal-count compare. Counts 0..limit-1 and restarts
//   at 0 after the terminal cycle, so tc pulses once every 'limit' cycles.
//   The caller may change 'limit' on the cycle after tc (the count is 0 then).
// Ports:
//   clk    : clock, rising edge
//   rst_n  : synchronous active-low reset (count -> 0)
//   limit  : period in cycles (>= 1)
//   tc     : high during the last cycle of the current period
module seven_segment_prescaler #(
  parameter int CW = 17
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [CW-1:0] limit,
  output logic          tc
);

  logic [CW-1:0] count_reg;

  assign tc = (count_reg == (limit - CW'(1)));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_reg <= '0;
    end else if (tc) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/seven_segment_scanner.sv
// seven_segment_scanner
//   Time-multiplexes NUM_DIGITS hex digits onto a shared segment bus. Each digit
//   is driven for REFRESH_DIV cycles, followed by BLANK_CYCLES cycles with every
//   anode off. A new display value is taken through a one-entry pending buffer
//   (valid/ready handshake) and only becomes visible when digit_idx wraps to 0,
//   so a frame never mixes old and new digits.
//   Optional build macro SEVSEG_LZ_BLANK_EN: suppress leading zero digits
//   (digit 0 is always shown).
// Ports:
//   clk        : clock, rising edge
//   rst_n      : synchronous active-low reset
//   load_valid : new display value offered
//   load_ready : pending buffer empty, a value can be accepted
//   load_data  : 4*NUM_DIGITS nibbles, digit 0 in bits [3:0]
//   load_dp    : decimal-point request per digit
//   nibble_out : nibble of the selected digit (to the segment decoder)
//   an_out     : active-low one-cold digit enables
//   dp_out     : active-high decimal point of the driven digit
//   digit_idx  : index of the selected digit
module seven_segment_scanner
  import seven_segment_pkg::*;
#(
  parameter int NUM_DIGITS   = DEFAULT_NUM_DIGITS,
  parameter int REFRESH_DIV  = DEFAULT_REFRESH_DIV,
  parameter int BLANK_CYCLES = DEFAULT_BLANK_CYCLES
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          load_valid,
  output logic                          load_ready,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  input  logic [NUM_DIGITS-1:0]         load_dp,
  output logic [3:0]                    nibble_out,
  output logic [NUM_DIGITS-1:0]         an_out,
  output logic                          dp_out,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx
);

  localparam int IDX_W   = $clog2(NUM_DIGITS);
  localparam int MAX_CNT = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  scan_state_t             state_reg, state_next;
  logic [IDX_W-1:0]        digit_idx_reg, digit_idx_next;
  logic                    pending_valid_reg;
  logic [4*NUM_DIGITS-1:0] pending_data_reg, display_data_reg;
  logic [NUM_DIGITS-1:0]   pending_dp_reg, display_dp_reg;
  logic [CW-1:0]           limit;
  logic                    tc;
  logic                    last_digit;
  logic                    frame_wrap;
  logic                    load_accept;
  logic                    digit_suppressed;
  logic [3:0]              digit_nibble [NUM_DIGITS];

  // The period being timed follows the current state; the counter is at 0
  // whenever the state changes, so switching the limit is glitch-free.
  assign limit = (state_reg == DRIVE) ? CW'(REFRESH_DIV) : CW'(BLANK_CYCLES);

  seven_segment_prescaler #(
    .CW(CW)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .limit (limit),
    .tc    (tc)
  );

  assign last_digit  = (digit_idx_reg == IDX_W'(NUM_DIGITS - 1));
  assign frame_wrap  = (state_reg == BLANK) && tc && last_digit;
  assign load_ready  = ~pending_valid_reg;
  assign load_accept = load_valid && ~pending_valid_reg;
  assign digit_idx   = digit_idx_reg;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= BLANK;
      digit_idx_reg <= '0;
    end else begin
      state_reg     <= state_next;
      digit_idx_reg <= digit_idx_next;
    end
  end

  // FSM: next state; the digit advances when leaving BLANK
  always_comb begin
    state_next     = state_reg;
    digit_idx_next = digit_idx_reg;
    case (state_reg)
      BLANK: begin
        if (tc) begin
          state_next     = DRIVE;
          digit_idx_next = last_digit ? '0 : digit_idx_reg + IDX_W'(1);
        end
      end
      DRIVE: begin
        if (tc) begin
          state_next = BLANK;
        end
      end
      default: state_next = BLANK;
    endcase
  end

  // Pending buffer and display register. The display only changes on the
  // frame wrap, i.e. on the same edge that selects digit 0 again.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pending_valid_reg <= 1'b0;
      pending_data_reg  <= '0;
      pending_dp_reg    <= '0;
      display_data_reg  <= '0;
      display_dp_reg    <= '0;
    end else begin
      if (frame_wrap && pending_valid_reg) begin
        display_data_reg  <= pending_data_reg;
        display_dp_reg    <= pending_dp_reg;
        pending_valid_reg <= 1'b0;
      end
      // Accept only happens with the buffer empty, so it never collides
      // with the copy above.
      if (load_accept) begin
        pending_data_reg  <= load_data;
        pending_dp_reg    <= load_dp;
        pending_valid_reg <= 1'b1;
      end
    end
  end

  for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nibble
    assign digit_nibble[gi] = display_data_reg[4*gi +: 4];
  end

`ifdef SEVSEG_LZ_BLANK_EN
  // upper_zero[i]: digit i and every digit above it are zero.
  logic [NUM_DIGITS-1:1] upper_zero;
  logic [NUM_DIGITS-1:0] suppress;

  assign suppress[0] = 1'b0;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_lz
    if (gi == NUM_DIGITS - 1) begin : g_top
      assign upper_zero[gi] = (digit_nibble[gi] == 4'h0);
    end else begin : g_mid
      assign upper_zero[gi] = (digit_nibble[gi] == 4'h0) && upper_zero[gi+1];
    end
    assign suppress[gi] = upper_zero[gi];
  end

  assign digit_suppressed = suppress[digit_idx_reg];
`else
  assign digit_suppressed = 1'b0;
`endif

  assign nibble_out = digit_nibble[digit_idx_reg];

  // FSM: outputs. A suppressed digit also keeps its decimal point dark.
  always_comb begin
    an_out = '1;
    dp_out = 1'b0;
    if ((state_reg == DRIVE) && !digit_suppressed) begin
      an_out[digit_idx_reg] = 1'b0;
      dp_out                = display_dp_reg[digit_idx_reg];
    end
  end

endmodule

// File: tb/tb_seven_segment_scanner.sv
// tb_seven_segment_scanner
//   Directed bench for seven_segment_scanner with NUM_DIGITS=4, REFRESH_DIV=4,
//   BLANK_CYCLES=1 (4 drive cycles + 1 blank cycle per digit, 20-cycle frame).
//   Table of load vectors with expected per-digit nibble/dp/lit state, plus
//   hand-written sequences for reset timing, back-pressure, mid-frame loads
//   and reset during a pending load. Expectations follow SEVSEG_LZ_BLANK_EN.
module tb_seven_segment_scanner;

`ifdef SEVSEG_LZ_BLANK_EN
  localparam bit LZ = 1'b1;
`else
  localparam bit LZ = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_valid;
  logic        load_ready;
  logic [15:0] load_data;
  logic [3:0]  load_dp;
  logic [3:0]  nibble_out;
  logic [3:0]  an_out;
  logic        dp_out;
  logic [1:0]  digit_idx;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [15:0] exp_nib;  // expected nibble per digit, digit 0 in [3:0]
    logic [3:0]  exp_dp;   // expected dp_out per digit
    logic [3:0]  exp_lit;  // 1 = anode expected low while that digit is driven
  } vec_t;

  vec_t vecs [4];

  seven_segment_scanner #(
    .NUM_DIGITS   (4),
    .REFRESH_DIV  (4),
    .BLANK_CYCLES (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .load_dp    (load_dp),
    .nibble_out (nibble_out),
    .an_out     (an_out),
    .dp_out     (dp_out),
    .digit_idx  (digit_idx)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("pass %s value=%0h", name, act);
    end
  endtask

  // Advance until digit_idx moves onto 'target' (entry into DRIVE of that digit).
  task automatic wait_idx(input logic [1:0] target);
    logic [1:0] prev;
    bit hit;
    prev = digit_idx;
    hit  = 1'b0;
    for (int n = 0; n < 60 && !hit; n++) begin
      step();
      if (digit_idx == target && prev != target) hit = 1'b1;
      prev = digit_idx;
    end
    if (!hit) begin
      checks++;
      failures++;
      $display("FAIL wait_idx%0d actual=timeout required=transition", target);
    end
  endtask

  // One-cycle load; inputs are scrambled afterwards to show they are not resampled.
  task automatic do_load(input logic [15:0] data, input logic [3:0] dp);
    for (int n = 0; n < 60 && !load_ready; n++) step();
    if (!load_ready) begin
      checks++;
      failures++;
      $display("FAIL load_wait actual=timeout required=load_ready");
    end
    load_valid = 1'b1;
    load_data  = data;
    load_dp    = dp;
    step();
    load_valid = 1'b0;
    load_data  = 16'hDEAD;
    load_dp    = 4'hF;
    check("ready_after_load", load_ready, 1'b0);
  endtask

  task automatic check_digit(input string tag, input logic [1:0] d,
                             input logic [3:0] nib, input logic dp, input logic lit);
    logic [3:0] exp_an;
    exp_an = lit ? ~(4'b0001 << d) : 4'b1111;
    check($sformatf("%s_d%0d_idx", tag, d), digit_idx, d);
    check($sformatf("%s_d%0d_nib", tag, d), nibble_out, nib);
    check($sformatf("%s_d%0d_an", tag, d), an_out, exp_an);
    check($sformatf("%s_d%0d_dp", tag, d), dp_out, dp);
  endtask

  initial begin
`ifdef SEVSEG_LZ_BLANK_EN
    vecs[0] = '{data: 16'h12AF, dp: 4'b0100, exp_nib: 16'h12AF, exp_dp: 4'b0100, exp_lit: 4'b1111};
    vecs[1] = '{data: 16'h0050, dp: 4'b0000, exp_nib: 16'h0050, exp_dp: 4'b0000, exp_lit: 4'b0011};
    vecs[2] = '{data: 16'h0000, dp: 4'b1000, exp_nib: 16'h0000, exp_dp: 4'b0000, exp_lit: 4'b0001};
    vecs[3] = '{data: 16'h8C03, dp: 4'b0001, exp_nib: 16'h8C03, exp_dp: 4'b0001, exp_lit: 4'b1111};
`else
    vecs[0] = '{data: 16'h12AF, dp: 4'b0100, exp_nib: 16'h12AF, exp_dp: 4'b0100, exp_lit: 4'b1111};
    vecs[1] = '{data: 16'h0050, dp: 4'b0000, exp_nib: 16'h0050, exp_dp: 4'b0000, exp_lit: 4'b1111};
    vecs[2] = '{data: 16'h0000, dp: 4'b1000, exp_nib: 16'h0000, exp_dp: 4'b1000, exp_lit: 4'b1111};
    vecs[3] = '{data: 16'h8C03, dp: 4'b0001, exp_nib: 16'h8C03, exp_dp: 4'b0001, exp_lit: 4'b1111};
`endif

    rst_n      = 1'b0;
    load_valid = 1'b0;
    load_data  = 16'h0000;
    load_dp    = 4'h0;

    // Reset held three cycles, then released.
    repeat (3) step();
    check("rst_an", an_out, 4'b1111);
    check("rst_dp", dp_out, 1'b0);
    check("rst_nib", nibble_out, 4'h0);
    check("rst_idx", digit_idx, 2'd0);
    check("rst_ready", load_ready, 1'b1);
    rst_n = 1'b1;

    // First DRIVE is digit 1, one blank cycle after release.
    step();
    check("first_idx", digit_idx, 2'd1);
    check("first_an", an_out, LZ ? 4'b1111 : 4'b1101);
    // Digit driven for 4 cycles, then exactly one blank cycle.
    repeat (3) step();
    check("drive_last_an", an_out, LZ ? 4'b1111 : 4'b1101);
    step();
    check("blank_an", an_out, 4'b1111);
    check("blank_dp", dp_out, 1'b0);
    check("blank_idx", digit_idx, 2'd1);
    step();
    check("next_idx", digit_idx, 2'd2);
    check("next_an", an_out, LZ ? 4'b1111 : 4'b1011);

    // Table-driven loads: each vector appears at the next frame boundary.
    for (int v = 0; v < 4; v++) begin
      do_load(vecs[v].data, vecs[v].dp);
      wait_idx(2'd0);
      check($sformatf("v%0d_ready_boundary", v), load_ready, 1'b1);
      for (int d = 0; d < 4; d++) begin
        if (d != 0) wait_idx(2'(d));
        check_digit($sformatf("v%0d", v), 2'(d), vecs[v].exp_nib[4*d +: 4],
                    vecs[v].exp_dp[d], vecs[v].exp_lit[d]);
      end
    end

    // Back-pressure: second value held valid while the buffer is full.
    for (int n = 0; n < 60 && !load_ready; n++) step();
    load_valid = 1'b1;
    load_data  = 16'h1111;
    load_dp    = 4'h0;
    step();
    load_data  = 16'h2222;
    check("hold_ready_low", load_ready, 1'b0);
    step();
    check("hold_ready_low2", load_ready, 1'b0);
    wait_idx(2'd0);
    check("hold_ready_boundary", load_ready, 1'b1);
    check("hold_f1_d0_nib", nibble_out, 4'h1);
    step();
    load_valid = 1'b0;
    load_data  = 16'hBEEF;
    check("hold_accepted", load_ready, 1'b0);
    for (int d = 1; d < 4; d++) begin
      wait_idx(2'(d));
      check($sformatf("hold_f1_d%0d_nib", d), nibble_out, 4'h1);
    end
    wait_idx(2'd0);
    check("hold_f2_d0_nib", nibble_out, 4'h2);
    wait_idx(2'd1);
    check("hold_f2_d1_nib", nibble_out, 4'h2);

    // Mid-frame load must not tear the current frame.
    do_load(16'h3333, 4'h0);
    wait_idx(2'd2);
    check("mid_d2_nib", nibble_out, 4'h2);
    wait_idx(2'd3);
    check("mid_d3_nib", nibble_out, 4'h2);
    wait_idx(2'd0);
    check("mid_next_d0_nib", nibble_out, 4'h3);

    // Reset while driving digit 2 with a value pending.
    wait_idx(2'd2);
    do_load(16'h9876, 4'hF);
    check("prerst_an", an_out, 4'b1011);
    rst_n = 1'b0;
    step();
    check("midrst_an", an_out, 4'b1111);
    check("midrst_idx", digit_idx, 2'd0);
    check("midrst_nib", nibble_out, 4'h0);
    check("midrst_dp", dp_out, 1'b0);
    check("midrst_ready", load_ready, 1'b1);
    rst_n = 1'b1;
    step();
    check("postrst_idx", digit_idx, 2'd1);
    check("postrst_nib", nibble_out, 4'h0);
    check("postrst_an", an_out, LZ ? 4'b1111 : 4'b1101);
    wait_idx(2'd0);
    check("discard_nib", nibble_out, 4'h0);
    check("discard_dp", dp_out, 1'b0);
    check("discard_an", an_out, 4'b1110);
    check("discard_ready", load_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
SEVEN_SEGMENT_SCANNER -- requirements
Module: seven_segment_scanner

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits (2..8).
REQ-002 SHALL have parameter REFRESH_DIV, default 100000: clock cycles each digit is driven (>=2).
REQ-003 SHALL have parameter BLANK_CYCLES, default 16: cycles with all anodes off between digits (>=1).
REQ-004 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port load_valid, input, 1: new display value offered.
REQ-007 SHALL have port load_ready, output, 1: scanner can accept a value.
REQ-008 SHALL have port load_data, input, 4*NUM_DIGITS: one hex nibble per digit; digit 0 = bits [3:0].
REQ-009 SHALL have port load_dp, input, NUM_DIGITS: decimal-point request per digit.
REQ-010 SHALL have port nibble_out, output, 4: nibble for the current digit, feeding seven_segment_decoder input.
REQ-011 SHALL have port an_out, output, NUM_DIGITS: digit enables, active-low, one-cold.
REQ-012 SHALL have port dp_out, output, 1: decimal point for the current digit, active-high.
REQ-013 SHALL have port digit_idx, output, clog2(NUM_DIGITS): index of the digit currently selected.

Function
REQ-014 SHALL accept a load on any cycle with load_valid && load_ready, capturing load_data/load_dp into a pending buffer.
REQ-015 SHALL drive load_ready = not pending_valid, registered; at most one pending value.
REQ-016 SHALL keep load_data and load_dp sampled only on the accept cycle; later changes are ignored.
REQ-017 SHALL have FSM states BLANK and DRIVE with one cycle counter.
REQ-018 In DRIVE, SHALL assert an_out[digit_idx] low, others high; after REFRESH_DIV cycles SHALL go to BLANK.
REQ-019 In BLANK, SHALL hold an_out all ones and dp_out 0; after BLANK_CYCLES cycles SHALL advance digit_idx and go to DRIVE.
REQ-020 SHALL wrap digit_idx from NUM_DIGITS-1 to 0 (frame boundary).
REQ-021 At the frame boundary, if pending_valid, SHALL copy pending into the display register and clear pending_valid in the same cycle; load_ready rises the next cycle.
REQ-022 SHALL never change the display register mid-frame (no tearing); load-to-display latency is bounded by one full frame.
REQ-023 SHALL drive nibble_out and dp_out combinationally from display register [digit_idx]; nibble_out valid in both states.
REQ-024 A load_valid held while load_ready is 0 SHALL wait, unaccepted, without data loss.

Reset
REQ-025 With rst_n low at a clock edge, SHALL set state BLANK, counter 0, digit_idx 0, display register all zero, pending_valid 0.
REQ-026 During and after reset SHALL output an_out all ones, dp_out 0, nibble_out 0, load_ready 1 (first cycle after release).
REQ-027 Reset mid-frame or mid-load SHALL discard the pending value; the first DRIVE after reset starts BLANK_CYCLES cycles after release, on digit 1.

Configuration
REQ-028 With macro SEVSEG_LZ_BLANK_EN defined, SHALL suppress leading zeros: a digit whose nibble is 0 and all higher digits are 0 keeps its anode high during DRIVE; digit 0 is never suppressed; dp does not defeat suppression.
REQ-029 Without SEVSEG_LZ_BLANK_EN, SHALL drive every digit in DRIVE regardless of value.

Structure
REQ-030 SHALL place state enum (BLANK, DRIVE) and default parameter constants in package seven_segment_pkg.
REQ-031 SHALL implement the cycle counter and terminal-count compare in sub-module seven_segment_prescaler.

Verification (NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1)
REQ-032 Reset held 3 cycles, released -> an_out=4'b1111, load_ready=1, one cycle later an_out=4'b1101, digit_idx=1.
REQ-033 Load 16'h12AF, dp=4'b0100 -> after next frame boundary digits show F,A,2,1; dp_out=1 only while digit_idx=2.
REQ-034 Load 16'h1111 then load_valid held with 16'h2222 -> load_ready=0 until boundary, 1111 shown first frame, 2222 accepted after and shown following frame.
REQ-035 Load issued mid-frame -> nibble_out for remaining digits of that frame still shows old value.
REQ-036 With SEVSEG_LZ_BLANK_EN, load 16'h0050 -> digits 3,2 anodes stay high; digit 1 shows 5, digit 0 shows 0; 16'h0000 -> only digit 0 lit.
REQ-037 rst_n low during DRIVE of digit 2 with pending load -> next cycle an_out=4'b1111, display 0, load_ready=1, pending discarded.
